alu_negate_scheduler: RTL and testbench
=======================================

ALU_NEGATE_SCHEDULER -- requirements
Module: alu_negate_scheduler

Interface
REQ-001 Parameter BUSY_CYCLES, default 1, meaning: execute-phase cycles (1..15) before result capture.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 clr_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  scheduler accepts requester N this cycle.
REQ-006 req0_op / req1_op  input  2  00 negate, 01 absolute, 10 pass, 11 reserved.
REQ-007 req0_a / req1_a  input  32  signed operand.
REQ-008 resp_valid  output  1  response held for the granted requester.
REQ-009 resp_ready  input  1  response consumer accepts.
REQ-010 resp_id  output  1  index of the requester being answered.
REQ-011 resp_result  output  32  operation result.
REQ-012 resp_ovf  output  1  two's-complement overflow (negating 0x80000000).
REQ-013 resp_err  output  1  reserved op code received.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL share one instance of the 32-bit two's-complement negate datapath (invert, add 1, carry-out discarded) between two requesters.
REQ-016 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-017 In IDLE, the grant SHALL follow round-robin order: with one request valid it wins; with both valid, the requester not served last wins.
REQ-018 reqN_ready SHALL be asserted combinationally, in IDLE only, for the granted requester only; both readies SHALL be 0 in EXEC and RESP.
REQ-019 On reqN_valid & reqN_ready, the block SHALL latch op, operand and id, clear the cycle counter, and enter EXEC.
REQ-020 EXEC SHALL last exactly BUSY_CYCLES cycles; on its last cycle the result, ovf and err SHALL be registered and the state SHALL enter RESP.
REQ-021 Result rules: negate -> ~a+1; absolute -> a[31] ? ~a+1 : a; pass -> a; reserved -> result 0, err 1.
REQ-022 resp_ovf SHALL be 1 only when op is negate or absolute and a == 0x80000000 (the result is then 0x80000000).
REQ-023 In RESP, resp_valid SHALL be 1, with resp_id, resp_result, resp_ovf and resp_err held stable until resp_valid & resp_ready.
REQ-024 On response acceptance, the state SHALL return to IDLE and the last-served pointer SHALL update to resp_id; no new grant SHALL occur in that same cycle.
REQ-025 Minimum request-to-request spacing SHALL therefore be BUSY_CYCLES+2 cycles.
REQ-026 resp_valid SHALL rise BUSY_CYCLES+1 cycles after the accepting handshake edge.
REQ-027 Requester valid or operand changes while not granted SHALL have no effect; requesters hold valid and operands until ready.
REQ-028 resp_result, resp_ovf and resp_err SHALL be 0 whenever resp_valid is 0.

Reset
REQ-029 clr_n low SHALL immediately force: state IDLE, resp_valid 0, resp_id 0, resp_result 0, resp_ovf 0, resp_err 0, busy 0, counter 0, and the last-served pointer to 1 (req0 wins first).
REQ-030 Reset during EXEC or RESP SHALL discard the transaction; no response for it SHALL appear after release.
REQ-031 The first grant SHALL be possible on the first rising edge after clr_n deasserts.

Verification
REQ-032 req0 negate a=5, BUSY_CYCLES=1 -> resp_valid two cycles after handshake; result 0xFFFFFFFB, id 0, ovf 0, err 0.
REQ-033 Both valid after reset with 2 transactions each -> service order req0, req1, req0, req1; each req only readies in IDLE.
REQ-034 Negate 0x80000000 -> result 0x80000000, ovf 1; absolute 0xFFFFFFF6 -> 0x0000000A, ovf 0; pass 0x12345678 -> unchanged.
REQ-035 resp_ready low for 5 cycles in RESP -> outputs stable, busy 1, both readies 0 throughout; accept -> IDLE next cycle.
REQ-036 clr_n pulsed low mid-EXEC -> all outputs 0 asynchronously; no resp_valid afterwards until a new handshake.
REQ-037 req1 op 11, a=7 -> resp_result 0, resp_err 1, resp_id 1, ovf 0.

Source files
------------

// File: rtl/alu_negate_scheduler.sv
// Two-requester scheduler sharing one 32-bit two's-complement negate datapath.
// Round-robin grant in IDLE, fixed-length EXEC phase, then a held response.
module alu_negate_scheduler #(
  parameter int unsigned BUSY_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_ovf,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0]  LAST_CNT = 4'(BUSY_CYCLES - 1);
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  state_e      state_q;
  logic        last_q;
  logic [3:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic        id_q;
  logic [31:0] result_q;
  logic        ovf_q;
  logic        err_q;
  logic        resp_valid_q;

  logic        grant1_s;
  logic        idle_s;
  logic [31:0] neg_s;
  logic [31:0] result_d;
  logic        ovf_d;
  logic        err_d;

  // req1 wins when it is the only requester, or when both ask and req0 went last
  assign idle_s     = (state_q == ST_IDLE);
  assign grant1_s   = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = idle_s & req0_valid & ~grant1_s;
  assign req1_ready = idle_s & grant1_s;

  assign neg_s = ~a_q + 32'd1;

  always_comb begin
    result_d = 32'd0;
    ovf_d    = 1'b0;
    err_d    = 1'b0;
    case (op_q)
      2'b00: begin
        result_d = neg_s;
        ovf_d    = (a_q == INT_MIN);
      end
      2'b01: begin
        result_d = a_q[31] ? neg_s : a_q;
        ovf_d    = (a_q == INT_MIN);
      end
      2'b10: begin
        result_d = a_q;
      end
      default: begin
        err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      cnt_q        <= 4'd0;
      op_q         <= 2'd0;
      a_q          <= 32'd0;
      id_q         <= 1'b0;
      result_q     <= 32'd0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0_ready | req1_ready) begin
            op_q    <= grant1_s ? req1_op : req0_op;
            a_q     <= grant1_s ? req1_a : req0_a;
            id_q    <= grant1_s;
            cnt_q   <= 4'd0;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == LAST_CNT) begin
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_RESP: begin
          // response fields return to zero so they are only nonzero while valid
          if (resp_ready) begin
            last_q       <= id_q;
            result_q     <= 32'd0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_ovf    = ovf_q;
  assign resp_err    = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_negate_scheduler.sv
// Randomized bench for alu_negate_scheduler: pending-request model with
// round-robin arbitration and arithmetic result reference.
module tb_alu_negate_scheduler;

  localparam int B = 1;

  logic        clk;
  logic        clr_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req1_a;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result;
  logic        resp_ovf, resp_err, busy;

  int n_vec;
  int n_err;

  bit          pend_v  [2];
  logic [1:0]  pend_op [2];
  logic [31:0] pend_a  [2];
  int          last_srv;

  alu_negate_scheduler #(.BUSY_CYCLES(B)) dut (
    .clk(clk), .clr_n(clr_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_ovf(resp_ovf), .resp_err(resp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a);
    case (op)
      2'd0:    return 32'd0 - a;
      2'd1:    return ($signed(a) < 0) ? 32'd0 - a : a;
      2'd2:    return a;
      default: return 32'd0;
    endcase
  endfunction

  // Idle requesters put junk on their buses; it must be ignored.
  task automatic drive();
    req0_valid = pend_v[0];
    req0_op    = pend_v[0] ? pend_op[0] : 2'($urandom_range(0, 3));
    req0_a     = pend_v[0] ? pend_a[0] : $urandom;
    req1_valid = pend_v[1];
    req1_op    = pend_v[1] ? pend_op[1] : 2'($urandom_range(0, 3));
    req1_a     = pend_v[1] ? pend_a[1] : $urandom;
  endtask

  task automatic set_pend(input int i, input logic [1:0] op, input logic [31:0] a);
    pend_v[i]  = 1'b1;
    pend_op[i] = op;
    pend_a[i]  = a;
  endtask

  // Starts just after a falling edge with the DUT expected in IDLE.
  task automatic run_round(input int stall);
    int          w;
    int          lat;
    logic [1:0]  op;
    logic [31:0] a, er;
    logic        eo, ee;
    if (pend_v[0] && pend_v[1]) w = (last_srv == 1) ? 0 : 1;
    else                        w = pend_v[0] ? 0 : 1;
    op = pend_op[w];
    a  = pend_a[w];
    er = ref_result(op, a);
    eo = (op < 2'd2) && (a == 32'h8000_0000);
    ee = (op == 2'd3);
    drive();
    #1;
    check_eq("ready0_idle", req0_ready, (w == 0) ? 32'd1 : 32'd0);
    check_eq("ready1_idle", req1_ready, (w == 1) ? 32'd1 : 32'd0);
    check_eq("busy_idle", busy, 32'd0);
    @(posedge clk);
    #1;
    pend_v[w] = 1'b0;
    drive();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      check_eq("ready0_busy", req0_ready, 32'd0);
      check_eq("ready1_busy", req1_ready, 32'd0);
      check_eq("busy_busy", busy, 32'd1);
      if (!resp_valid) check_eq("result_zero_exec", resp_result, 32'd0);
    end while (!resp_valid && lat < 40);
    check_eq("resp_latency", lat, B + 1);
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge clk);
      check_eq("resp_valid", resp_valid, 32'd1);
      check_eq("resp_id", resp_id, w);
      check_eq("resp_result", resp_result, er);
      check_eq("resp_ovf", resp_ovf, eo);
      check_eq("resp_err", resp_err, ee);
      check_eq("ready0_resp", req0_ready, 32'd0);
      check_eq("ready1_resp", req1_ready, 32'd0);
      check_eq("busy_resp", busy, 32'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check_eq("valid_after_accept", resp_valid, 32'd0);
    check_eq("busy_after_accept", busy, 32'd0);
    check_eq("result_after_accept", resp_result, 32'd0);
    last_srv = w;
  endtask

  task automatic rand_operand(output logic [31:0] a);
    case ($urandom_range(0, 5))
      0:       a = 32'h8000_0000;
      1:       a = 32'd0;
      2:       a = 32'hFFFF_FFFF;
      3:       a = 32'h7FFF_FFFF;
      default: a = $urandom;
    endcase
  endtask

  initial begin
    logic [31:0] ra;
    n_vec      = 0;
    n_err      = 0;
    last_srv   = 1;
    pend_v[0]  = 1'b0;
    pend_v[1]  = 1'b0;
    pend_op[0] = 2'd0; pend_op[1] = 2'd0;
    pend_a[0]  = 32'd0; pend_a[1] = 32'd0;
    clr_n      = 1'b0;
    resp_ready = 1'b0;
    drive();
    #12;
    check_eq("rst_resp_valid", resp_valid, 32'd0);
    check_eq("rst_resp_id", resp_id, 32'd0);
    check_eq("rst_resp_result", resp_result, 32'd0);
    check_eq("rst_resp_ovf", resp_ovf, 32'd0);
    check_eq("rst_resp_err", resp_err, 32'd0);
    check_eq("rst_busy", busy, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    // Both requesters pending from reset: order must be 0,1,0,1
    set_pend(0, 2'd0, 32'd5);
    set_pend(1, 2'd2, 32'h1234_5678);
    run_round(0);
    set_pend(0, 2'd0, 32'h8000_0000);
    run_round(1);
    set_pend(1, 2'd3, 32'd7);
    run_round(0);
    run_round(2);
    set_pend(0, 2'd1, 32'hFFFF_FFF6);
    run_round(5);

    // Reset pulse in the middle of EXEC discards the transaction
    set_pend(0, 2'd0, 32'd9);
    drive();
    @(posedge clk);
    #1;
    pend_v[0] = 1'b0;
    drive();
    @(negedge clk);
    check_eq("pre_rst_busy", busy, 32'd1);
    #2;
    clr_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 32'd0);
    check_eq("arst_resp_valid", resp_valid, 32'd0);
    check_eq("arst_resp_id", resp_id, 32'd0);
    check_eq("arst_resp_result", resp_result, 32'd0);
    check_eq("arst_resp_ovf", resp_ovf, 32'd0);
    check_eq("arst_resp_err", resp_err, 32'd0);
    @(negedge clk);
    clr_n    = 1'b1;
    last_srv = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("no_resp_after_rst", resp_valid, 32'd0);
    end

    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend_v[i] && ($urandom_range(0, 1) == 1)) begin
          rand_operand(ra);
          set_pend(i, 2'($urandom_range(0, 3)), ra);
        end
      end
      if (!pend_v[0] && !pend_v[1]) begin
        rand_operand(ra);
        set_pend($urandom_range(0, 1), 2'($urandom_range(0, 3)), ra);
      end
      run_round($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
